// File: rtl/bp_mc_to_cce_mmio.sv
// Bridges one manycore endpoint request at a time into a BedRock uncached command and formats the reply.
// Latency: capture, SEND until ready, WAIT until response, then ACK (in_yumi_o) and RET (returning_v_o); requester is held until ACK.
module bp_mc_to_cce_mmio
  #(parameter int paddr_width_p = 40
    , parameter int mc_data_width_p = 32
    , parameter int mc_addr_width_p = 16
    , parameter logic [paddr_width_p-1:0] cfg_base_p = 40'h0020_0000
    , parameter logic [paddr_width_p-1:0] clint_base_p = 40'h0030_0000
    , parameter logic [paddr_width_p-1:0] ucode_offset_p = 40'h0000_8000
    , parameter int cce_data_width_p = 64
    // header = {payload[7:0], size[2:0], addr, subop[3:0], msg_type[3:0]}, data sits above it
    , localparam int hdr_width_lp = paddr_width_p + 19
    , localparam int msg_width_lp = hdr_width_lp + cce_data_width_p
    )
  (input  logic                        clk_i
   , input  logic                      reset_i

   , input  logic                      in_v_i
   , input  logic [mc_data_width_p-1:0] in_data_i
   , input  logic [3:0]                in_mask_i
   , input  logic [mc_addr_width_p-1:0] in_addr_i
   , input  logic                      in_we_i
   // {is_byte_op, is_hex_op, is_unsigned_op, part_sel[1:0]}
   , input  logic [4:0]                in_load_info_i
   , output logic                      in_yumi_o

   , output logic [31:0]               returning_data_o
   , output logic                      returning_v_o

   , output logic [msg_width_lp-1:0]   io_cmd_o
   , output logic                      io_cmd_v_o
   , input  logic                      io_cmd_ready_and_i

   , input  logic [msg_width_lp-1:0]   io_resp_i
   , input  logic                      io_resp_v_i
   , output logic                      io_resp_yumi_o
   );

  typedef enum logic [2:0] {e_idle, e_send, e_wait, e_ack, e_ret} state_e;

  localparam logic [3:0] e_bedrock_mem_uc_rd = 4'd2;
  localparam logic [3:0] e_bedrock_mem_uc_wr = 4'd3;
  // Size encoded as log2(bytes)
  localparam logic [2:0] e_size_1 = 3'd0;
  localparam logic [2:0] e_size_2 = 3'd1;
  localparam logic [2:0] e_size_4 = 3'd2;
  localparam logic [1:0] lce_id_lp = 2'b10;

  state_e state_r;
  logic [2:0] size_r;
  logic       unsigned_r;
  logic       we_r;

  logic [3:0]  dev;
  logic [11:0] off;
  logic        is_byte_op, is_hex_op, is_unsigned_op;
  logic [1:0]  part_sel;

  assign dev            = in_addr_i[15:12];
  assign off            = in_addr_i[11:0];
  assign is_byte_op     = in_load_info_i[4];
  assign is_hex_op      = in_load_info_i[3];
  assign is_unsigned_op = in_load_info_i[2];
  assign part_sel       = in_load_info_i[1:0];

  logic [paddr_width_p-1:0] base_addr, req_addr;
  logic [2:0]  st_size, req_size;
  logic [1:0]  st_off, req_off;
  logic [31:0] st_shifted;
  logic [cce_data_width_p-1:0] req_data;
  logic [hdr_width_lp-1:0] req_hdr;

  always_comb begin
    case (dev)
      4'd2:    base_addr = clint_base_p;
      4'd1:    base_addr = cfg_base_p + ucode_offset_p;
      default: base_addr = cfg_base_p;
    endcase
  end

  // Byte-lane mask to size/offset; irregular masks fall back to a full word
  always_comb begin
    st_size = e_size_4;
    st_off  = 2'd0;
    case (in_mask_i)
      4'h3: begin st_size = e_size_2; st_off = 2'd0; end
      4'hc: begin st_size = e_size_2; st_off = 2'd2; end
      4'h1: begin st_size = e_size_1; st_off = 2'd0; end
      4'h2: begin st_size = e_size_1; st_off = 2'd1; end
      4'h4: begin st_size = e_size_1; st_off = 2'd2; end
      4'h8: begin st_size = e_size_1; st_off = 2'd3; end
      default: begin st_size = e_size_4; st_off = 2'd0; end
    endcase
  end

  always_comb begin
    if (in_we_i) begin
      req_size = st_size;
      req_off  = st_off;
    end else begin
      req_size = is_byte_op ? e_size_1 : (is_hex_op ? e_size_2 : e_size_4);
      req_off  = part_sel;
    end
    req_addr = base_addr
             + {{(paddr_width_p-12){1'b0}}, off}
             + {{(paddr_width_p-2){1'b0}}, req_off};

    st_shifted = in_data_i[31:0] >> {st_off, 3'b000};
    req_data   = '0;
    if (in_we_i) begin
      case (st_size)
        e_size_1: req_data = {(cce_data_width_p/8){st_shifted[7:0]}};
        e_size_2: req_data = {(cce_data_width_p/16){st_shifted[15:0]}};
        default:  req_data = {(cce_data_width_p/32){st_shifted}};
      endcase
    end

    req_hdr = {lce_id_lp, 6'b0, req_size, req_addr, 4'b0,
               (in_we_i ? e_bedrock_mem_uc_wr : e_bedrock_mem_uc_rd)};
  end

  logic [31:0] resp_word, resp_fmt;
  assign resp_word = io_resp_i[hdr_width_lp +: 32];

  always_comb begin
    case (size_r)
      e_size_1: resp_fmt = {{24{~unsigned_r & resp_word[7]}}, resp_word[7:0]};
      e_size_2: resp_fmt = {{16{~unsigned_r & resp_word[15]}}, resp_word[15:0]};
      default:  resp_fmt = resp_word;
    endcase
    if (we_r)
      resp_fmt = 32'h0;
  end

  // Gated by reset so a response present during reset is left unconsumed
  assign io_resp_yumi_o = (state_r == e_wait) & io_resp_v_i & ~reset_i;

  logic unused_resp;
  assign unused_resp = ^{io_resp_i[hdr_width_lp-1:0], io_resp_i[msg_width_lp-1:hdr_width_lp+32]};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r          <= e_idle;
      io_cmd_o         <= '0;
      io_cmd_v_o       <= 1'b0;
      in_yumi_o        <= 1'b0;
      returning_v_o    <= 1'b0;
      returning_data_o <= 32'h0;
      size_r           <= e_size_4;
      unsigned_r       <= 1'b0;
      we_r             <= 1'b0;
    end else begin
      in_yumi_o     <= 1'b0;
      returning_v_o <= 1'b0;
      case (state_r)
        e_idle: begin
          if (in_v_i) begin
            io_cmd_o   <= {req_data, req_hdr};
            size_r     <= req_size;
            unsigned_r <= is_unsigned_op;
            we_r       <= in_we_i;
            if (in_we_i && (in_mask_i == 4'h0)) begin
              returning_data_o <= 32'h0;
              in_yumi_o        <= 1'b1;
              state_r          <= e_ack;
            end else begin
              io_cmd_v_o <= 1'b1;
              state_r    <= e_send;
            end
          end
        end
        e_send: begin
          if (io_cmd_ready_and_i) begin
            io_cmd_v_o <= 1'b0;
            state_r    <= e_wait;
          end
        end
        e_wait: begin
          if (io_resp_v_i) begin
            returning_data_o <= resp_fmt;
            in_yumi_o        <= 1'b1;
            state_r          <= e_ack;
          end
        end
        e_ack: begin
          returning_v_o <= 1'b1;
          state_r       <= e_ret;
        end
        e_ret: begin
          state_r <= e_idle;
        end
        default: begin
          io_cmd_v_o <= 1'b0;
          state_r    <= e_idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bp_mc_to_cce_mmio.sv
// Directed vector bench for bp_mc_to_cce_mmio with a small BP-side responder.
module tb_bp_mc_to_cce_mmio;
  localparam int PA = 40;
  localparam int DW = 64;
  localparam int HW = PA + 19;
  localparam int MW = HW + DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_i;
  logic          in_v_i;
  logic [31:0]   in_data_i;
  logic [3:0]    in_mask_i;
  logic [15:0]   in_addr_i;
  logic          in_we_i;
  logic [4:0]    in_load_info_i;
  logic          in_yumi_o;
  logic [31:0]   returning_data_o;
  logic          returning_v_o;
  logic [MW-1:0] io_cmd_o;
  logic          io_cmd_v_o;
  logic          io_cmd_ready_and_i;
  logic [MW-1:0] io_resp_i;
  logic          io_resp_v_i;
  logic          io_resp_yumi_o;

  bp_mc_to_cce_mmio dut (
    .clk_i(clk), .reset_i(reset_i),
    .in_v_i(in_v_i), .in_data_i(in_data_i), .in_mask_i(in_mask_i),
    .in_addr_i(in_addr_i), .in_we_i(in_we_i), .in_load_info_i(in_load_info_i),
    .in_yumi_o(in_yumi_o),
    .returning_data_o(returning_data_o), .returning_v_o(returning_v_o),
    .io_cmd_o(io_cmd_o), .io_cmd_v_o(io_cmd_v_o), .io_cmd_ready_and_i(io_cmd_ready_and_i),
    .io_resp_i(io_resp_i), .io_resp_v_i(io_resp_v_i), .io_resp_yumi_o(io_resp_yumi_o)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic        we;
    logic [4:0]  info;
    logic [63:0] resp;
    logic        nocmd;
    logic [3:0]  typ;
    logic [39:0] eaddr;
    logic [2:0]  esize;
    logic [63:0] edata;
    logic [31:0] eret;
    int          rdy;
    int          rsp;
    bit          tog;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] a, input logic [31:0] d, input logic [3:0] m,
                              input logic we, input logic [4:0] info, input logic [63:0] resp,
                              input logic nocmd, input logic [3:0] typ, input logic [39:0] ea,
                              input logic [2:0] es, input logic [63:0] ed, input logic [31:0] er,
                              input int rdy, input int rsp, input bit tog);
    vec_t v;
    v.addr = a; v.data = d; v.mask = m; v.we = we; v.info = info; v.resp = resp;
    v.nocmd = nocmd; v.typ = typ; v.eaddr = ea; v.esize = es; v.edata = ed; v.eret = er;
    v.rdy = rdy; v.rsp = rsp; v.tog = tog;
    return v;
  endfunction

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
  task automatic run_txn(input vec_t v, input string tag);
    int cyc = 0, cmd_cyc = 0, hs_n = 0, yumi_n = 0, ret_n = 0;
    int yumi_at = -100, ret_at = -100, rsp_state = 0, rsp_cnt = 0, post = 0;
    bit cmd_seen = 0, cmd_moved = 0, stray = 0;
    logic [MW-1:0] cmd0 = '0;
    logic [31:0] ret_dat = 32'h0;
    in_addr_i = v.addr; in_data_i = v.data; in_mask_i = v.mask;
    in_we_i = v.we; in_load_info_i = v.info; in_v_i = 1'b1;
    while (cyc < 80 && post < 4) begin
      if (rsp_state == 3) begin io_resp_v_i = 1'b0; rsp_state = 4; end
      if (rsp_state == 1) begin
        if (rsp_cnt == 0) begin
          io_resp_i = {v.resp, {HW{1'b0}}};
          io_resp_v_i = 1'b1;
          rsp_state = 2;
        end else rsp_cnt--;
      end
      io_cmd_ready_and_i = 1'b0;
      if (io_cmd_v_o) begin
        if (!cmd_seen) begin cmd_seen = 1; cmd0 = io_cmd_o; end
        else if (io_cmd_o !== cmd0) cmd_moved = 1;
        if (cmd_cyc >= v.rdy) begin
          io_cmd_ready_and_i = 1'b1;
          hs_n++;
          rsp_state = 1;
          rsp_cnt = v.rsp;
        end
        cmd_cyc++;
      end
      if (in_yumi_o) begin yumi_n++; yumi_at = cyc; in_v_i = 1'b0; end
      else if (v.tog && yumi_n == 0 && cyc > 0) in_v_i = ~in_v_i;
      if (returning_v_o) begin ret_n++; ret_at = cyc; ret_dat = returning_data_o; end
      #1;
      if (io_resp_yumi_o) begin
        if (rsp_state == 2) rsp_state = 3;
        else stray = 1;
      end
      if (ret_n > 0) post++;
      @(posedge clk); #1;
      cyc++;
    end
    io_cmd_ready_and_i = 1'b0;
    io_resp_v_i = 1'b0;
    in_v_i = 1'b0;
    chk({tag, " cmd_present"}, 64'(cmd_seen), 64'(!v.nocmd));
    chk({tag, " cmd_handshakes"}, 64'(hs_n), v.nocmd ? 64'd0 : 64'd1);
    if (cmd_seen) begin
      chk({tag, " msg_type"}, 64'(cmd0[3:0]), 64'(v.typ));
      chk({tag, " subop"}, 64'(cmd0[7:4]), 64'd0);
      chk({tag, " addr"}, 64'(cmd0[47:8]), 64'(v.eaddr));
      chk({tag, " size"}, 64'(cmd0[50:48]), 64'(v.esize));
      chk({tag, " payload_rest"}, 64'(cmd0[56:51]), 64'd0);
      chk({tag, " lce_id"}, 64'(cmd0[58:57]), 64'd2);
      chk({tag, " data"}, cmd0[122:59], v.edata);
      chk({tag, " cmd_stable"}, 64'(cmd_moved), 64'd0);
    end
    chk({tag, " yumi_pulses"}, 64'(yumi_n), 64'd1);
    chk({tag, " ret_pulses"}, 64'(ret_n), 64'd1);
    chk({tag, " ret_after_yumi"}, 64'(ret_at - yumi_at), 64'd1);
    chk({tag, " ret_data"}, 64'(ret_dat), 64'(v.eret));
    chk({tag, " resp_consumed"}, 64'(rsp_state), v.nocmd ? 64'd0 : 64'd4);
    chk({tag, " stray_resp_yumi"}, 64'(stray), 64'd0);
  endtask

  vec_t vecs[13];

  initial begin
    int waited;
    vecs[0]  = mk(16'h2010, 32'hDEADBEEF, 4'hf, 1, 5'b00000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 4'd3, 40'h30_0010, 3'd2, 64'hDEADBEEF_DEADBEEF, 32'h0, 0, 0, 0);
    vecs[1]  = mk(16'h0004, 32'h0, 4'h0, 0, 5'b10011, 64'h0000_0000_0000_0080, 0, 4'd2, 40'h20_0007, 3'd0, 64'h0, 32'hFFFFFF80, 0, 0, 0);
    vecs[2]  = mk(16'h0004, 32'h0, 4'h0, 0, 5'b10111, 64'h0000_0000_0000_0080, 0, 4'd2, 40'h20_0007, 3'd0, 64'h0, 32'h00000080, 0, 0, 0);
    vecs[3]  = mk(16'h0004, 32'h0, 4'h0, 0, 5'b10011, 64'h0000_0000_0000_0080, 0, 4'd2, 40'h20_0007, 3'd0, 64'h0, 32'hFFFFFF80, 10, 5, 1);
    vecs[4]  = mk(16'h2000, 32'hCAFEBABE, 4'h0, 1, 5'b00000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 4'd0, 40'h0, 3'd0, 64'h0, 32'h0, 0, 0, 0);
    vecs[5]  = mk(16'h1008, 32'h12345678, 4'hc, 1, 5'b00000, 64'h5555_5555_5555_5555, 0, 4'd3, 40'h20_800A, 3'd1, 64'h1234_1234_1234_1234, 32'h0, 0, 0, 0);
    vecs[6]  = mk(16'h1100, 32'h0, 4'h0, 0, 5'b01010, 64'h1122_3344_5566_8001, 0, 4'd2, 40'h20_8102, 3'd1, 64'h0, 32'hFFFF8001, 0, 0, 0);
    vecs[7]  = mk(16'h3FFC, 32'h0, 4'h0, 0, 5'b00000, 64'hAAAA_BBBB_CAFE_F00D, 0, 4'd2, 40'h20_0FFC, 3'd2, 64'h0, 32'hCAFEF00D, 0, 0, 0);
    vecs[8]  = mk(16'h2020, 32'hA1B2C3D4, 4'h4, 1, 5'b00000, 64'h1, 0, 4'd3, 40'h30_0022, 3'd0, 64'hB2B2_B2B2_B2B2_B2B2, 32'h0, 0, 0, 0);
    vecs[9]  = mk(16'h0040, 32'h01020304, 4'h5, 1, 5'b00000, 64'h2, 0, 4'd3, 40'h20_0040, 3'd2, 64'h0102_0304_0102_0304, 32'h0, 0, 0, 0);
    vecs[10] = mk(16'h0FFF, 32'hFFFF0042, 4'h3, 1, 5'b00000, 64'h3, 0, 4'd3, 40'h20_0FFF, 3'd1, 64'h0042_0042_0042_0042, 32'h0, 0, 0, 0);
    vecs[11] = mk(16'h2004, 32'h77000000, 4'h8, 1, 5'b00000, 64'h4, 0, 4'd3, 40'h30_0007, 3'd0, 64'h7777_7777_7777_7777, 32'h0, 0, 0, 0);
    vecs[12] = mk(16'h2000, 32'h0, 4'h0, 0, 5'b01100, 64'h0000_0000_0000_9ABC, 0, 4'd2, 40'h30_0000, 3'd1, 64'h0, 32'h00009ABC, 0, 0, 0);

    reset_i = 1'b1; in_v_i = 1'b0; in_data_i = '0; in_mask_i = '0; in_addr_i = '0;
    in_we_i = 1'b0; in_load_info_i = '0; io_cmd_ready_and_i = 1'b0;
    io_resp_i = '0; io_resp_v_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_i = 1'b0;
    io_resp_v_i = 1'b1;
    #1;
    chk("reset in_yumi", 64'(in_yumi_o), 64'd0);
    chk("reset returning_v", 64'(returning_v_o), 64'd0);
    chk("reset io_cmd_v", 64'(io_cmd_v_o), 64'd0);
    chk("reset io_resp_yumi", 64'(io_resp_yumi_o), 64'd0);
    chk("reset returning_data", 64'(returning_data_o), 64'd0);
    io_resp_v_i = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++)
      run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset while waiting on a valid response
    in_addr_i = vecs[1].addr; in_data_i = vecs[1].data; in_mask_i = vecs[1].mask;
    in_we_i = vecs[1].we; in_load_info_i = vecs[1].info; in_v_i = 1'b1;
    io_cmd_ready_and_i = 1'b1;
    waited = 0;
    while (!io_cmd_v_o && waited < 10) begin @(posedge clk); #1; waited++; end
    chk("rst_seq reach_send", 64'(io_cmd_v_o), 64'd1);
    in_v_i = 1'b0;
    @(posedge clk); #1;
    io_cmd_ready_and_i = 1'b0;
    chk("rst_seq in_wait cmd_v", 64'(io_cmd_v_o), 64'd0);
    reset_i = 1'b1;
    io_resp_i = {vecs[1].resp, {HW{1'b0}}};
    io_resp_v_i = 1'b1;
    #1;
    chk("rst_seq resp_yumi_during_reset", 64'(io_resp_yumi_o), 64'd0);
    @(posedge clk); #1;
    chk("rst_seq in_yumi", 64'(in_yumi_o), 64'd0);
    chk("rst_seq returning_v", 64'(returning_v_o), 64'd0);
    chk("rst_seq io_cmd_v", 64'(io_cmd_v_o), 64'd0);
    chk("rst_seq returning_data", 64'(returning_data_o), 64'd0);
    chk("rst_seq io_cmd", io_cmd_o[63:0], 64'd0);
    reset_i = 1'b0;
    #1;
    chk("rst_seq resp_yumi_after_reset", 64'(io_resp_yumi_o), 64'd0);
    io_resp_v_i = 1'b0;
    @(posedge clk); #1;
    run_txn(vecs[1], "post_reset");
    run_txn(vecs[5], "post_reset_store");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
